ram4k_fill_check: RTL
=====================

# ram4k_fill_check

Bus-master engine that drives the `ram4k` write/read port: on command it fills a contiguous address range with an arithmetic data pattern, then reads the range back and checks every word. It sits on the initiator side of the `ram4k` interface (`in`, `address`, `load`, `out`). It is used for memory bring-up and self-test, and reports pass/fail, error count and the first failing address.

## Interface
- `ADDR_W`, default 12: RAM address width (4096 words).
- `DATA_W`, default 16: RAM word width.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high; returns the block to IDLE immediately.
- `start`  in  1: command strobe; sampled only in IDLE.
- `base`  in  ADDR_W: first address of the range.
- `count`  in  ADDR_W+1: number of words, 0..4096.
- `seed`  in  DATA_W: data written to `base`.
- `step`  in  DATA_W: increment between consecutive words.
- `ram_in`  out  DATA_W: write data to RAM `in`.
- `ram_addr`  out  ADDR_W: RAM `address`.
- `ram_load`  out  1: RAM `load` (write enable).
- `ram_out`  in  DATA_W: RAM `out`; combinational read of `ram_addr`.
- `busy`  out  1: high in WRITE and READ.
- `done`  out  1: one-cycle pulse at completion.
- `pass`  out  1: 1 when the last run had zero mismatches.
- `err_count`  out  ADDR_W+1: mismatches in the last run, saturating at 4096.
- `first_err_addr`  out  ADDR_W: address of the first mismatch; 0 if none.

## Operation
- **States:** IDLE, WRITE, READ, DONE.
- **IDLE, start=1:**
  - Latch `base`, `count`, `seed` and `step`.
  - Clear `err_count` and `first_err_addr`; set `pass`=1.
  - Set index i=0 and expected data d=`seed`.
  - Next state is WRITE if `count`≠0, else DONE.
- **WRITE:**
  - `ram_load`=1, `ram_addr`=(base+i) mod 2^ADDR_W, `ram_in`=d.
  - Each edge: i+=1, d=(d+step) mod 2^DATA_W.
  - After word i=count-1: go to READ, reset i=0 and d=seed.
- **READ:**
  - `ram_load`=0, `ram_addr`=(base+i) mod 2^ADDR_W, `ram_in` holds its last value.
  - Each edge: compare `ram_out` with d.
  - On mismatch: `err_count`+=1 (saturating) and `pass`=0. If this is the first mismatch, capture `ram_addr` into `first_err_addr`.
  - After word count-1: go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **Address wrap:** modulo 4096. A range passing 4095 continues at 0.
- **Data wrap:** modulo 2^16. Arithmetic is unsigned; carries are discarded.
- **count=4096:** the full memory is written and checked; the start address is not revisited.
- **Busy:** `start` is ignored while not in IDLE, including in DONE.
- **Result hold:** `pass`, `err_count` and `first_err_addr` hold until the next accepted `start` or `reset`.
- **Reset, at any time:**
  - State=IDLE, `ram_load`=0, `ram_addr`=0, `ram_in`=0.
  - `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_addr`=0.
  - These take effect without waiting for a clock edge. An interrupted run produces no `done` pulse.

## Timing
- `start` is accepted at edge E0.
- **WRITE:** cycles 1..count follow E0; the RAM captures word i at the edge ending that cycle.
- **READ:** cycles count+1..2·count. Each compare uses `ram_out` at the edge ending the cycle, so there is no read latency.
- **DONE:** `done` is high in cycle 2·count+1. Total latency from `start` to `done` is 2·count+1 cycles. With count=0, `done` is high in the cycle after E0.
- **Status update:** `busy` rises in cycle 1 and falls when DONE is entered. Results are final when `done` is high.
- **Outputs:** `ram_load`, `ram_addr` and `ram_in` are glitch-free functions of registered state only.

## Test plan
- **Basic run:** base=0, count=4, seed=0, step=123, real RAM.
  - Writes 0,123,246,369 at addresses 0..3.
  - `done` arrives 9 cycles after `start`; `pass`=1, `err_count`=0.
- **Wrap:** base=4094, count=4, seed=16'hFFFF, step=1.
  - Addresses 4094,4095,0,1 receive data FFFF,0000,0001,0002.
  - `pass`=1.
- **Zero length:** count=0.
  - `done` arrives 1 cycle after `start`; `ram_load` never asserts; `pass`=1, `err_count`=0.
- **Fault injection:** count=8, base=0; the bench XORs `ram_out` with 1 when `ram_addr` is 5 or 6.
  - `err_count`=2, `first_err_addr`=5, `pass`=0.
- **Reset mid-WRITE:** assert `reset` in WRITE cycle 2.
  - `ram_load`, `busy` and `pass` go to 0 before the next edge.
  - A fresh `start` then completes normally.
- **Start while busy:** pulse `start` with different `base` during READ.
  - It is ignored; the original run's results are unchanged.

Source files
------------

// File: rtl/ram4k_fill_check.sv
// ============================================================================
// ram4k_fill_check : fills a RAM address range with an arithmetic pattern,
//                    reads it back and reports pass / error count / first bad address
// Revision 1.0
// ============================================================================
`default_nettype none

module ram4k_fill_check #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] step,
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] C_ERR_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q,  state_d;
    logic [ADDR_W-1:0] base_q,   base_d;
    logic [ADDR_W:0]   cnt_q,    cnt_d;
    logic [DATA_W-1:0] seed_q,   seed_d;
    logic [DATA_W-1:0] step_q,   step_d;
    logic [ADDR_W:0]   idx_q,    idx_d;
    logic [DATA_W-1:0] dat_q,    dat_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              load_q,   load_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              pass_q,   pass_d;
    logic [ADDR_W:0]   errs_q,   errs_d;
    logic [ADDR_W-1:0] ferr_q,   ferr_d;

    logic              w_last;
    logic [DATA_W-1:0] w_dat_next;

    assign w_last     = (idx_q == (cnt_q - 1'b1));
    assign w_dat_next = dat_q + step_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        step_d  = step_q;
        idx_d   = idx_q;
        dat_d   = dat_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        errs_d  = errs_q;
        ferr_d  = ferr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = base;
                    cnt_d  = count;
                    seed_d = seed;
                    step_d = step;
                    errs_d = '0;
                    ferr_d = '0;
                    pass_d = 1'b1;
                    idx_d  = '0;
                    dat_d  = seed;
                    addr_d = base;
                    if (count != '0) begin
                        state_d = S_WRITE;
                        load_d  = 1'b1;
                        wdata_d = seed;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_WRITE: begin
                if (w_last) begin
                    // Rewind to the start of the range; write data stays on the bus.
                    state_d = S_READ;
                    load_d  = 1'b0;
                    idx_d   = '0;
                    dat_d   = seed_q;
                    addr_d  = base_q;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    dat_d   = w_dat_next;
                    wdata_d = w_dat_next;
                    addr_d  = addr_q + 1'b1;
                end
            end

            S_READ: begin
                if (ram_out != dat_q) begin
                    pass_d = 1'b0;
                    if (errs_q != C_ERR_MAX) begin
                        errs_d = errs_q + 1'b1;
                    end
                    if (pass_q) begin
                        ferr_d = addr_q;
                    end
                end
                if (w_last) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    dat_d  = w_dat_next;
                    addr_d = addr_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            seed_q  <= '0;
            step_q  <= '0;
            idx_q   <= '0;
            dat_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            errs_q  <= '0;
            ferr_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            errs_q  <= errs_d;
            ferr_q  <= ferr_d;
        end
    end

    assign ram_in         = wdata_q;
    assign ram_addr       = addr_q;
    assign ram_load       = load_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = errs_q;
    assign first_err_addr = ferr_q;

endmodule

`default_nettype wire
